// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow errors and an
// optional first-word-fall-through read port.
module fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr,
  input  logic [WIDTH-1:0]           din,
  input  logic                       rd,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] cnt,
  input  logic                       err_clr,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF = CW'(AF_LEVEL);
  localparam logic [CW-1:0] CNT_AE = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrop;
  logic [AW-1:0]    rdop;
  logic [CW-1:0]    cnt_nxt;
  logic             wr_ok;
  logic             rd_ok;

  // Accepts are judged on the registered flags, so a full FIFO still pops on
  // wr&rd and an empty FIFO still pushes on wr&rd.
  assign wr_ok = wr & ~full;
  assign rd_ok = rd & ~empty;

  // Next occupancy; flags are registered from this so they never lag cnt.
  always_comb begin
    cnt_nxt = cnt;
    case ({wr_ok, rd_ok})
      2'b10:   cnt_nxt = cnt + CNT_ONE;
      2'b01:   cnt_nxt = cnt - CNT_ONE;
      default: cnt_nxt = cnt;
    endcase
  end

  // Control state: pointers, occupancy, status flags and sticky errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrop         <= '0;
      rdop         <= '0;
      cnt          <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_ok) wrop <= wrop + PTR_ONE;
      if (rd_ok) rdop <= rdop + PTR_ONE;
      cnt          <= cnt_nxt;
      full         <= (cnt_nxt == CNT_FULL);
      empty        <= (cnt_nxt == '0);
      almost_full  <= (cnt_nxt >= CNT_AF);
      almost_empty <= (cnt_nxt <= CNT_AE);
      // A new error in the same cycle as err_clr keeps the flag set.
      if (wr & full)   overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (rd & empty)  underflow <= 1'b1;
      else if (err_clr) underflow <= 1'b0;
    end
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wrop] <= din;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented combinationally while the FIFO holds data.
      always_comb begin
        dout = '0;
        if (!empty) dout = mem[rdop];
      end
    end else begin : g_std
      logic [WIDTH-1:0] dout_p1;

      // ---- read stage: registered output, holds on idle or rejected reads
      always_ff @(posedge clk or posedge rst) begin
        if (rst)        dout_p1 <= '0;
        else if (rd_ok) dout_p1 <= mem[rdop];
      end

      assign dout = dout_p1;
    end
  endgenerate

endmodule
